// File: rtl/pipe_hazard_if.sv
// Hazard-control bus between the 5-stage pipeline datapath and its hazard controller.
// The master is the pipeline side. The slave is the controller.
interface pipe_hazard_if #(
    parameter int AW = 4
);
    logic [AW-1:0] ra1_d;
    logic [AW-1:0] ra2_d;
    logic [AW-1:0] ra1_e;
    logic [AW-1:0] ra2_e;
    logic [AW-1:0] wa_e;
    logic [AW-1:0] wa_m;
    logic [AW-1:0] wa_w;
    logic          reg_write_m;
    logic          reg_write_w;
    logic          mem_to_reg_e;
    logic          branch_take_e;
    logic          mc_start_e;
    logic [1:0]    fwd_a_e;
    logic [1:0]    fwd_b_e;
    logic          stall_f;
    logic          stall_d;
    logic          stall_e;
    logic          flush_d;
    logic          flush_e;
    logic          flush_m;
    logic          mc_busy;
    logic          mc_done;

    modport master (
        output ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w,
        output reg_write_m, reg_write_w, mem_to_reg_e, branch_take_e, mc_start_e,
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e,
        input  flush_d, flush_e, flush_m, mc_busy, mc_done
    );

    modport slave (
        input  ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w,
        input  reg_write_m, reg_write_w, mem_to_reg_e, branch_take_e, mc_start_e,
        output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e,
        output flush_d, flush_e, flush_m, mc_busy, mc_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline. It handles forwarding, load-use stalls, branch flushes and multicycle execute occupancy.
// All outputs are combinational from the FSM state and the bus inputs, and they are forced low while reset is asserted.
module pipe_hazard_ctrl #(
    parameter int AW     = 4,
    parameter int MC_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    pipe_hazard_if.slave  bus
);
    localparam int            CW       = $clog2(MC_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MC_LAT - 2);

    typedef enum logic [1:0] {IDLE, BUSY, LAST} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mc_busy_c;
    logic          hz_en;
    logic          lu;
    logic          br;

    // If M and W both match the source register, M holds the younger value and is selected.
    function automatic logic [1:0] fwd_sel(input logic rw_m, input logic [AW-1:0] wa_m,
                                           input logic rw_w, input logic [AW-1:0] wa_w,
                                           input logic [AW-1:0] ra);
        if (rw_m && (wa_m == ra))      return 2'b10;
        else if (rw_w && (wa_w == ra)) return 2'b01;
        else                           return 2'b00;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.mc_start_e) begin
                    cnt_d   = CNT_INIT;
                    state_d = (MC_LAT == 2) ? LAST : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = LAST;
            end
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // E is frozen while the multicycle unit is busy, so load-use and branch are evaluated only once E is released.
    assign mc_busy_c = reset && (((state_q == IDLE) && bus.mc_start_e) || (state_q == BUSY));
    assign hz_en     = reset && !mc_busy_c;
    assign lu        = hz_en && bus.mem_to_reg_e &&
                       ((bus.wa_e == bus.ra1_d) || (bus.wa_e == bus.ra2_d));
    assign br        = hz_en && bus.branch_take_e;

    assign bus.fwd_a_e = reset ? fwd_sel(bus.reg_write_m, bus.wa_m, bus.reg_write_w, bus.wa_w, bus.ra1_e) : 2'b00;
    assign bus.fwd_b_e = reset ? fwd_sel(bus.reg_write_m, bus.wa_m, bus.reg_write_w, bus.wa_w, bus.ra2_e) : 2'b00;
    assign bus.stall_f = mc_busy_c || lu;
    assign bus.stall_d = mc_busy_c || lu;
    assign bus.stall_e = mc_busy_c;
    assign bus.flush_d = br;
    assign bus.flush_e = br || lu;
    assign bus.flush_m = mc_busy_c;
    assign bus.mc_busy = mc_busy_c;
    assign bus.mc_done = reset && (state_q == LAST);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl that runs two instances side by side, with MC_LAT=4 and MC_LAT=2.
// An occupancy-age reference model computes the expected outputs of both instances for every cycle.
module tb_pipe_hazard_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_if #(.AW(4)) b4 ();
    pipe_hazard_if #(.AW(4)) b2 ();

    pipe_hazard_ctrl #(.AW(4), .MC_LAT(4)) dut4 (.clk(clk), .reset(rst_n), .bus(b4.slave));
    pipe_hazard_ctrl #(.AW(4), .MC_LAT(2)) dut2 (.clk(clk), .reset(rst_n), .bus(b2.slave));

    typedef struct packed {
        logic       rst;
        logic [3:0] ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
        logic       rw_m, rw_w, ld, br, st;
    } stim_t;

    typedef struct packed {
        logic [11:0] e4;
        logic [11:0] e2;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   age4 = -1;
    int   age2 = -1;
    int   cyc = 0;

    function automatic logic [1:0] fwd(input stim_t s, input logic [3:0] ra);
        if (s.rw_m && s.wa_m == ra) return 2'b10;
        if (s.rw_w && s.wa_w == ra) return 2'b01;
        return 2'b00;
    endfunction

    // age = number of cycles since the multicycle op entered E; -1 means no op is in flight.
    function automatic logic [11:0] model(input stim_t s, input int lat, input int age_in,
                                          output int age_out);
        int   cur;
        logic busy, done, lu, br;
        if (!s.rst) begin
            age_out = -1;
            return 12'd0;
        end
        cur     = (age_in < 0) ? (s.st ? 0 : -1) : age_in;
        busy    = (cur >= 0) && (cur <= lat - 2);
        done    = (cur == lat - 1);
        age_out = (cur >= 0 && cur < lat - 1) ? cur + 1 : -1;
        lu      = !busy && s.ld && (s.wa_e == s.ra1_d || s.wa_e == s.ra2_d);
        br      = !busy && s.br;
        return {fwd(s, s.ra1_e), fwd(s, s.ra2_e), busy | lu, busy | lu, busy,
                br, br | lu, busy, busy, done};
    endfunction

    task automatic drive(input stim_t s);
        rst_n            = s.rst;
        b4.ra1_d = s.ra1_d;  b2.ra1_d = s.ra1_d;
        b4.ra2_d = s.ra2_d;  b2.ra2_d = s.ra2_d;
        b4.ra1_e = s.ra1_e;  b2.ra1_e = s.ra1_e;
        b4.ra2_e = s.ra2_e;  b2.ra2_e = s.ra2_e;
        b4.wa_e  = s.wa_e;   b2.wa_e  = s.wa_e;
        b4.wa_m  = s.wa_m;   b2.wa_m  = s.wa_m;
        b4.wa_w  = s.wa_w;   b2.wa_w  = s.wa_w;
        b4.reg_write_m   = s.rw_m;  b2.reg_write_m   = s.rw_m;
        b4.reg_write_w   = s.rw_w;  b2.reg_write_w   = s.rw_w;
        b4.mem_to_reg_e  = s.ld;    b2.mem_to_reg_e  = s.ld;
        b4.branch_take_e = s.br;    b2.branch_take_e = s.br;
        b4.mc_start_e    = s.st;    b2.mc_start_e    = s.st;
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        int   a4, a2;
        @(posedge clk);
        #1;
        drive(s);
        e.e4  = model(s, 4, age4, a4);
        e.e2  = model(s, 2, age2, a2);
        e.cyc = cyc;
        age4  = a4;
        age2  = a2;
        cyc++;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int c, input logic [11:0] got, input logic [11:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b want=%b (fa fb sf sd se fd fe fm busy done)",
                      name, c, got, want);
    endtask

    exp_t        mon_e;
    logic [11:0] got4, got2;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            got4 = {b4.fwd_a_e, b4.fwd_b_e, b4.stall_f, b4.stall_d, b4.stall_e,
                    b4.flush_d, b4.flush_e, b4.flush_m, b4.mc_busy, b4.mc_done};
            got2 = {b2.fwd_a_e, b2.fwd_b_e, b2.stall_f, b2.stall_d, b2.stall_e,
                    b2.flush_d, b2.flush_e, b2.flush_m, b2.mc_busy, b2.mc_done};
            chk("lat4", mon_e.cyc, got4, mon_e.e4);
            chk("lat2", mon_e.cyc, got2, mon_e.e2);
        end
    end

    stim_t s, base;
    initial begin
        s = '0;
        drive(s);
        base     = '0;
        base.rst = 1'b1;

        // Reset held with every input high, then released with inputs low.
        s = '1; s.rst = 1'b0; apply(s); apply(s);
        apply(base); apply(base);

        // Forwarding priority between M and W.
        s = base; s.ra1_e = 4'd3; s.wa_m = 4'd3; s.rw_m = 1'b1;
        s.wa_w = 4'd3; s.rw_w = 1'b1; s.ra2_e = 4'd5;
        apply(s);
        s.rw_m = 1'b0; apply(s);
        s.ra2_e = 4'd3; apply(s);

        // Load-use stall.
        s = base; s.ld = 1'b1; s.wa_e = 4'd7; s.ra2_d = 4'd7; apply(s);
        s.ra2_d = 4'd8; apply(s);

        // Branch flush, alone and combined with a load-use hazard.
        s = base; s.br = 1'b1; apply(s);
        s.ld = 1'b1; s.wa_e = 4'd7; s.ra1_d = 4'd7; apply(s);

        // Multicycle op with mc_start_e held and a branch inside the busy window.
        s = base; s.st = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s.br = (i == 1 || i == 2);
            apply(s);
        end
        apply(base); apply(base);

        // Reset during BUSY, then a fresh multicycle op.
        s = base; s.st = 1'b1; apply(s);
        apply(base);
        s = base; s.rst = 1'b0; apply(s);
        apply(base);
        s = base; s.st = 1'b1; apply(s);
        for (int i = 0; i < 5; i++) apply(base);

        // Randomized traffic over a small register range so that address matches happen often.
        for (int n = 0; n < 600; n++) begin
            s.rst   = ($urandom_range(0, 49) != 0);
            s.ra1_d = 4'($urandom_range(0, 3));
            s.ra2_d = 4'($urandom_range(0, 3));
            s.ra1_e = 4'($urandom_range(0, 3));
            s.ra2_e = 4'($urandom_range(0, 3));
            s.wa_e  = 4'($urandom_range(0, 3));
            s.wa_m  = 4'($urandom_range(0, 3));
            s.wa_w  = 4'($urandom_range(0, 3));
            s.rw_m  = 1'($urandom_range(0, 1));
            s.rw_w  = 1'($urandom_range(0, 1));
            s.ld    = ($urandom_range(0, 2) == 0);
            s.st    = ($urandom_range(0, 5) == 0);
            s.br    = !s.st && ($urandom_range(0, 3) == 0);
            apply(s);
        end
        apply(base);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
